// File: rtl/dmem_bridge.sv
// M-stage data bridge: one SRAM-like bus transaction per load/store with byte lanes,
// store-data replication and aligned, extended load return. Stalls M until done.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic        mem_wenM,
  input  logic [1:0]  mem_sizeM,
  input  logic        mem_signedM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        stall_otherM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        addr_errM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q;
  logic        req_q, wr_q, sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;

  logic        misalign, start;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, shifted, rd_ext;

  // Size 11 is handled as a word everywhere, hence the test on size[1] only.
  assign misalign  = ((mem_sizeM == 2'b01) & addrM[0]) | (mem_sizeM[1] & (|addrM[1:0]));
  assign start     = mem_enM & ~misalign;
  assign addr_errM = mem_enM & misalign;

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = wdataM;
    case (mem_sizeM)
      2'b00: begin
        wstrb_d = 4'b0001 << addrM[1:0];
        wdata_d = {4{wdataM[7:0]}};
      end
      2'b01: begin
        wstrb_d = addrM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdataM[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!mem_wenM) wstrb_d = 4'b0000;
  end

  // Extraction uses the latched request, so M-stage input changes mid-flight are harmless.
  always_comb begin
    shifted = data_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      2'b01:   rd_ext = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      default: rd_ext = shifted;
    endcase
    if (wr_q) rd_ext = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q  <= addrM;
          size_q  <= mem_sizeM;
          sgn_q   <= mem_signedM;
          wr_q    <= mem_wenM;
          wstrb_q <= wstrb_d;
          wdata_q <= wdata_d;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (data_addr_ok) begin
          req_q <= 1'b0;
          if (data_data_ok) begin
            rdata_q <= rd_ext;
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: if (data_data_ok) begin
          rdata_q <= rd_ext;
          state_q <= DONE;
        end
        DONE: if (!stall_otherM) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stallM = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:     stallM = start;
        REQ,WAIT: stallM = 1'b1;
        default:  stallM = 1'b0;
      endcase
    end
  end

  assign readdataM  = rdata_q;
  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: latency, lanes, extension, misalignment, held DONE, reset.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enM = 1'b0, mem_wenM = 1'b0, mem_signedM = 1'b0, stall_otherM = 1'b0;
  logic [1:0]  mem_sizeM = 2'b00;
  logic [31:0] addrM = 32'h0, wdataM = 32'h0;
  logic [31:0] readdataM;
  logic        stallM, addr_errM, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'h0;

  int n_chk = 0;
  int n_fail = 0;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .mem_enM(mem_enM), .mem_wenM(mem_wenM), .mem_sizeM(mem_sizeM),
    .mem_signedM(mem_signedM), .addrM(addrM), .wdataM(wdataM), .stall_otherM(stall_otherM),
    .readdataM(readdataM), .stallM(stallM), .addr_errM(addr_errM), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the IDLE cycle; acks are raised in the cycles given. Returns at the DONE negedge.
  task automatic run(input string tag, input logic wen, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int aok, input int dok, input int exp_stall, input int exp_req,
                     input logic [31:0] exp_rd, input logic [3:0] exp_strb,
                     input logic [31:0] exp_wdata);
    int stalls = 0, reqs = 0;
    bit done = 0, got = 0;
    logic [3:0]  strb = 4'h0;
    logic [31:0] wdo = 32'h0, ado = 32'h0;
    logic        wro = 1'b0;
    mem_enM = 1'b1; mem_wenM = wen; mem_sizeM = sz; mem_signedM = sg;
    addrM = a; wdataM = wd; data_rdata = rd;
    for (int c = 0; c < 40; c++) begin
      data_addr_ok = (c == aok);
      data_data_ok = (c == dok);
      @(negedge clk);
      if (data_req) begin
        reqs++;
        if (!got) begin strb = data_wstrb; wdo = data_wdata; ado = data_addr; wro = data_wr; got = 1; end
      end
      if (!stallM) begin done = 1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_req"}, 32'(reqs), 32'(exp_req));
    chk({tag, "_rd"}, readdataM, exp_rd);
    chk({tag, "_strb"}, 32'(strb), 32'(exp_strb));
    chk({tag, "_addr"}, ado, a);
    chk({tag, "_wr"}, 32'(wro), 32'(wen));
    if (wen) chk({tag, "_wdata"}, wdo, exp_wdata);
  endtask

  task automatic leave_done();
    mem_enM = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(data_req), 0);
    chk("rst_stall", 32'(stallM), 0);
    chk("rst_rd", readdataM, 0);
    chk("rst_bus", {data_addr[15:0], data_wdata[7:0], data_wstrb, data_wr, data_size, 1'b0}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word load, zero wait
    run("wload", 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 2, 1, 32'hDEADBEEF, 4'h0, 32'h0);
    chk("wload_size", 32'(data_size), 32'd2);
    leave_done();

    // Byte loads at offset 3, signed then unsigned
    run("sbload", 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF1234, 1, 1, 2, 1, 32'hFFFFFF80, 4'h0, 32'h0);
    leave_done();
    run("ubload", 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF1234, 1, 1, 2, 1, 32'h00000080, 4'h0, 32'h0);
    leave_done();

    // Half loads: upper half signed, lower half unsigned
    run("shload", 0, 2'b01, 1, 32'h102, 32'h0, 32'h80017FFF, 1, 1, 2, 1, 32'hFFFF8001, 4'h0, 32'h0);
    leave_done();
    run("uhload", 0, 2'b01, 0, 32'h100, 32'h0, 32'h8001F00F, 1, 1, 2, 1, 32'h0000F00F, 4'h0, 32'h0);
    leave_done();

    // Half store, addr_ok in 3rd REQ cycle, data_ok two cycles after
    run("hstore", 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0, 3, 5, 6, 3, 32'h0, 4'hC, 32'hABCDABCD);
    chk("hstore_size", 32'(data_size), 32'd1);
    leave_done();

    // Byte store to lane 1, one WAIT cycle
    run("bstore", 1, 2'b00, 0, 32'h101, 32'h12345677, 32'h0, 1, 2, 3, 1, 32'h0, 4'h2, 32'h77777777);
    leave_done();

    // Size 11 acts as word
    run("wstore", 1, 2'b11, 0, 32'h10C, 32'hCAFEF00D, 32'h0, 1, 1, 2, 1, 32'h0, 4'hF, 32'hCAFEF00D);
    leave_done();

    // Misaligned accesses: flagged, no stall, no request
    mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = 2'b10; addrM = 32'h102;
    @(negedge clk);
    chk("mis_w_err", 32'(addr_errM), 1);
    chk("mis_w_stall", 32'(stallM), 0);
    @(posedge clk); #1;
    mem_sizeM = 2'b01; addrM = 32'h101;
    @(negedge clk);
    chk("mis_h_err", 32'(addr_errM), 1);
    chk("mis_h_req", 32'(data_req), 0);
    mem_sizeM = 2'b11; addrM = 32'h10E;
    #1 chk("mis_11_err", 32'(addr_errM), 1);
    mem_sizeM = 2'b00; addrM = 32'h103;
    #1 chk("byte_noerr", 32'(addr_errM), 0);
    mem_enM = 1'b0; mem_sizeM = 2'b10; addrM = 32'h102;
    #1 chk("noen_noerr", 32'(addr_errM), 0);
    @(posedge clk); #1;
    chk("mis_req_after", 32'(data_req), 0);

    // Held DONE: stall_otherM keeps state and data, no new request though mem_enM stays up
    stall_otherM = 1'b1;
    run("hold", 0, 2'b10, 0, 32'h400, 32'h0, 32'h11223344, 1, 1, 2, 1, 32'h11223344, 4'h0, 32'h0);
    data_rdata = 32'h99999999;
    addrM = 32'h500;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("hold_stall%0d", i), 32'(stallM), 0);
      chk($sformatf("hold_req%0d", i), 32'(data_req), 0);
      chk($sformatf("hold_rd%0d", i), readdataM, 32'h11223344);
    end
    stall_otherM = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_idle_stall", 32'(stallM), 1);
    mem_enM = 1'b0;
    @(posedge clk); #1;
    chk("hold_idle_req", 32'(data_req), 0);

    // Reset in REQ drops data_req without a clock edge
    mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = 2'b10; addrM = 32'h300;
    @(posedge clk); #1;
    mem_enM = 1'b0;
    @(negedge clk);
    chk("rreq_req_pre", 32'(data_req), 1);
    rst = 1'b1;
    #1 chk("rreq_req", 32'(data_req), 0);
    chk("rreq_stall", 32'(stallM), 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Load to set readdataM nonzero, then reset in WAIT
    run("pre", 0, 2'b10, 0, 32'h600, 32'h0, 32'hA5A5A5A5, 1, 1, 2, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
    leave_done();
    mem_enM = 1'b1; mem_wenM = 1'b0; mem_sizeM = 2'b10; addrM = 32'h300;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; mem_enM = 1'b0;
    @(negedge clk);
    chk("rwait_stall_pre", 32'(stallM), 1);
    rst = 1'b1;
    #1 chk("rwait_stall", 32'(stallM), 0);
    chk("rwait_rd", readdataM, 0);
    chk("rwait_req", 32'(data_req), 0);
    #1 rst = 1'b0;
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("late_ok_rd", readdataM, 0);
    chk("late_ok_stall", 32'(stallM), 0);
    chk("late_ok_req", 32'(data_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
